// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus CPU datapath: bus mux, register file, 64-bit ALU
// Optional macro DATAPATH_HILO_OUT_EN adds HI_Out/LO_Out as lowest-priority bus sources.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] MData_In,
  input  logic [4:0]       CONTROL,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             PC_Out,
  input  logic             MDR_Out,
  input  logic             ZHI_Out,
  input  logic             ZLO_Out,
  input  logic             R2_Out,
  input  logic             R4_Out,
`ifdef DATAPATH_HILO_OUT_EN
  input  logic             HI_Out,
  input  logic             LO_Out,
`endif
  input  logic             PC_In,
  input  logic             MDR_In,
  input  logic             MAR_In,
  input  logic             IR_In,
  input  logic             Y_In,
  input  logic             ZHI_In,
  input  logic             ZLO_In,
  input  logic             R2_In,
  input  logic             R4_In,
  input  logic             HI_In,
  input  logic             LO_In,
  output logic [WIDTH-1:0] BusMux_Out
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] pc, ir, mar, mdr, r2, r4, y, zhi, zlo, hi, lo;
  logic [WIDTH-1:0] bus;
  logic [2*WIDTH-1:0] alu;
  logic [2*WIDTH-1:0] mul_a, mul_b;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [SW-1:0] sh;

  always_comb begin
    bus = '0;
    if (PC_Out)       bus = pc;
    else if (MDR_Out) bus = mdr;
    else if (ZHI_Out) bus = zhi;
    else if (ZLO_Out) bus = zlo;
    else if (R2_Out)  bus = r2;
    else if (R4_Out)  bus = r4;
`ifdef DATAPATH_HILO_OUT_EN
    else if (HI_Out)  bus = hi;
    else if (LO_Out)  bus = lo;
`endif
  end

  assign BusMux_Out = bus;

  // Sign-extend both operands so the low 2*WIDTH bits of the product are the signed result.
  assign mul_a = {{WIDTH{y[WIDTH-1]}}, y};
  assign mul_b = {{WIDTH{bus[WIDTH-1]}}, bus};
  assign sh    = bus[SW-1:0];
  assign rot_r = {bus, bus} >> sh;
  assign rot_l = {bus, bus} << sh;

  always_comb begin
    alu = '0;
    if (IncPC) begin
      alu = {ZERO, WIDTH'(bus + 1'b1)};
    end else begin
      case (CONTROL)
        5'b00000: alu = {ZERO, y & bus};
        5'b00001: alu = {ZERO, y | bus};
        5'b00010: alu = mul_a * mul_b;
        5'b00011: alu = {ZERO, WIDTH'(y + bus)};
        5'b00100: alu = {ZERO, WIDTH'(y - bus)};
        5'b00101: alu = {ZERO, bus >> sh};
        5'b00110: alu = {ZERO, bus << sh};
        5'b00111: alu = {ZERO, WIDTH'(-bus)};
        5'b01000: alu = {ZERO, ~bus};
        5'b01001: alu = {ZERO, WIDTH'($signed(bus) >>> sh)};
        5'b01010: alu = {ZERO, rot_r[WIDTH-1:0]};
        5'b01011: alu = {ZERO, rot_l[2*WIDTH-1:WIDTH]};
        default:  alu = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      r2  <= '0;
      r4  <= '0;
      y   <= '0;
      zhi <= '0;
      zlo <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (PC_In)  pc  <= bus;
      if (IR_In)  ir  <= bus;
      if (MAR_In) mar <= bus;
      if (MDR_In) mdr <= Read ? MData_In : bus;
      if (R2_In)  r2  <= bus;
      if (R4_In)  r4  <= bus;
      if (Y_In)   y   <= bus;
      if (ZHI_In) zhi <= alu[2*WIDTH-1:WIDTH];
      if (ZLO_In) zlo <= alu[WIDTH-1:0];
      if (HI_In)  hi  <= bus;
      if (LO_In)  lo  <= bus;
    end
  end

  // IR and MAR (and HI/LO without bus outputs) have no consumer inside this block yet.
`ifdef DATAPATH_HILO_OUT_EN
  logic unused_state;
  assign unused_state = ^{ir, mar};
`else
  logic unused_state;
  assign unused_state = ^{ir, mar, hi, lo};
`endif

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench for datapath against a behavioural register/ALU model
module tb_datapath;

  localparam logic [21:0] PCO  = 22'd1 << 0;
  localparam logic [21:0] MDRO = 22'd1 << 1;
  localparam logic [21:0] ZHIO = 22'd1 << 2;
  localparam logic [21:0] ZLOO = 22'd1 << 3;
  localparam logic [21:0] R2O  = 22'd1 << 4;
  localparam logic [21:0] R4O  = 22'd1 << 5;
  localparam logic [21:0] HIO  = 22'd1 << 6;
  localparam logic [21:0] LOO  = 22'd1 << 7;
  localparam logic [21:0] PCI  = 22'd1 << 8;
  localparam logic [21:0] MDRI = 22'd1 << 9;
  localparam logic [21:0] MARI = 22'd1 << 10;
  localparam logic [21:0] IRI  = 22'd1 << 11;
  localparam logic [21:0] YI   = 22'd1 << 12;
  localparam logic [21:0] ZHII = 22'd1 << 13;
  localparam logic [21:0] ZLOI = 22'd1 << 14;
  localparam logic [21:0] R2I  = 22'd1 << 15;
  localparam logic [21:0] R4I  = 22'd1 << 16;
  localparam logic [21:0] HII  = 22'd1 << 17;
  localparam logic [21:0] LOI  = 22'd1 << 18;
  localparam logic [21:0] INC  = 22'd1 << 19;
  localparam logic [21:0] RD   = 22'd1 << 20;
  localparam logic [21:0] CLR  = 22'd1 << 21;

  logic        clk;
  logic [21:0] s;
  logic [4:0]  ctl;
  logic [31:0] md;
  logic [31:0] bus_out;
  logic        chk;

  int checks;
  int errors;
  logic [31:0] exp_q[$];
  string       name_q[$];

  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_r2, m_r4, m_y, m_zhi, m_zlo, m_hi, m_lo;

  datapath #(.WIDTH(32)) dut (
    .Clock(clk),
    .Clear(s[21]),
    .MData_In(md),
    .CONTROL(ctl),
    .IncPC(s[19]),
    .Read(s[20]),
    .PC_Out(s[0]),
    .MDR_Out(s[1]),
    .ZHI_Out(s[2]),
    .ZLO_Out(s[3]),
    .R2_Out(s[4]),
    .R4_Out(s[5]),
`ifdef DATAPATH_HILO_OUT_EN
    .HI_Out(s[6]),
    .LO_Out(s[7]),
`endif
    .PC_In(s[8]),
    .MDR_In(s[9]),
    .MAR_In(s[10]),
    .IR_In(s[11]),
    .Y_In(s[12]),
    .ZHI_In(s[13]),
    .ZLO_In(s[14]),
    .R2_In(s[15]),
    .R4_In(s[16]),
    .HI_In(s[17]),
    .LO_In(s[18]),
    .BusMux_Out(bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit has(input logic [21:0] st, input logic [21:0] m);
    return (st & m) != 22'd0;
  endfunction

  function automatic logic [31:0] model_bus(input logic [21:0] st);
    if (has(st, PCO))  return m_pc;
    if (has(st, MDRO)) return m_mdr;
    if (has(st, ZHIO)) return m_zhi;
    if (has(st, ZLOO)) return m_zlo;
    if (has(st, R2O))  return m_r2;
    if (has(st, R4O))  return m_r4;
`ifdef DATAPATH_HILO_OUT_EN
    if (has(st, HIO))  return m_hi;
    if (has(st, LOO))  return m_lo;
`endif
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] c, input bit inc);
    logic [31:0] r;
    longint      p;
    int          n;
    n = int'(b[4:0]);
    r = 32'h0;
    if (inc) return {32'h0, b + 32'd1};
    case (c)
      5'd0:  r = a & b;
      5'd1:  r = a | b;
      5'd2: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
      end
      5'd3:  r = a + b;
      5'd4:  r = a - b;
      5'd5:  r = b >> n;
      5'd6:  r = b << n;
      5'd7:  r = 32'd0 - b;
      5'd8:  r = ~b;
      5'd9:  r = 32'($signed(b) >>> n);
      5'd10: begin
        r = b;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      end
      5'd11: begin
        r = b;
        for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
      end
      default: return 64'h0;
    endcase
    return {32'h0, r};
  endfunction

  task automatic step(input logic [21:0] st, input logic [4:0] c, input logic [31:0] m,
                      input string nm, input bit use_k = 1'b0, input logic [31:0] k = 32'h0);
    logic [31:0] b;
    logic [63:0] r;
    @(posedge clk);
    #1;
    s   = st;
    ctl = c;
    md  = m;
    b = model_bus(st);
    exp_q.push_back(use_k ? k : b);
    name_q.push_back(nm);
    chk = 1'b1;
    r = model_alu(m_y, b, c, has(st, INC));
    if (has(st, CLR)) begin
      {m_pc, m_ir, m_mar, m_mdr, m_r2, m_r4, m_y, m_zhi, m_zlo, m_hi, m_lo} = '0;
    end else begin
      if (has(st, PCI))  m_pc  = b;
      if (has(st, IRI))  m_ir  = b;
      if (has(st, MARI)) m_mar = b;
      if (has(st, MDRI)) m_mdr = has(st, RD) ? m : b;
      if (has(st, R2I))  m_r2  = b;
      if (has(st, R4I))  m_r4  = b;
      if (has(st, YI))   m_y   = b;
      if (has(st, ZHII)) m_zhi = r[63:32];
      if (has(st, ZLOI)) m_zlo = r[31:0];
      if (has(st, HII))  m_hi  = b;
      if (has(st, LOI))  m_lo  = b;
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: bus=%h with no expected value queued", bus_out);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = name_q.pop_front();
        if (bus_out !== e) begin
          errors++;
          $display("FAIL %s: bus=%h expected %h", n, bus_out, e);
        end
      end
    end
  end

  initial begin
    logic [21:0] st;
    checks = 0;
    errors = 0;
    chk = 1'b0;
    s = '0;
    ctl = '0;
    md = '0;
    {m_pc, m_ir, m_mar, m_mdr, m_r2, m_r4, m_y, m_zhi, m_zlo, m_hi, m_lo} = '0;

    step(CLR | PCI | R2I | ZLOI, 5'd0, 32'h0, "reset_bus", 1'b1, 32'h0);
    step(22'd0, 5'd0, 32'h0, "idle_bus", 1'b1, 32'h0);
    step(PCO, 5'd0, 32'h0, "pc_after_reset", 1'b1, 32'h0);

    step(RD | MDRI, 5'd0, 32'd16, "mdr_read16");
    step(MDRO | R2I, 5'd0, 32'h0, "mdr_to_r2", 1'b1, 32'd16);
    step(RD | MDRI, 5'd0, 32'd32, "mdr_read32");
    step(MDRO | R4I, 5'd0, 32'h0, "mdr_to_r4", 1'b1, 32'd32);
    step(R2O, 5'd0, 32'h0, "r2_out", 1'b1, 32'd16);
    step(R2O | R4O, 5'd0, 32'h0, "prio_r2_over_r4", 1'b1, 32'd16);

    step(PCO | MARI | INC | ZHII | ZLOI, 5'd3, 32'h0, "incpc_src", 1'b1, 32'h0);
    step(ZLOO | PCI, 5'd0, 32'h0, "zlo_pc_plus1", 1'b1, 32'd1);
    step(PCO, 5'd0, 32'h0, "pc_is_1", 1'b1, 32'd1);

    step(R2O | YI, 5'd0, 32'h0, "y_from_r2", 1'b1, 32'd16);
    step(R4O | ZHII | ZLOI, 5'd2, 32'h0, "mul_operand", 1'b1, 32'd32);
    step(ZLOO | LOI, 5'd0, 32'h0, "mul_zlo_512", 1'b1, 32'd512);
    step(ZHIO | HII, 5'd0, 32'h0, "mul_zhi_0", 1'b1, 32'd0);
`ifdef DATAPATH_HILO_OUT_EN
    step(LOO, 5'd0, 32'h0, "lo_out_512", 1'b1, 32'd512);
    step(HIO, 5'd0, 32'h0, "hi_out_0", 1'b1, 32'd0);
`endif

    step(RD | MDRI, 5'd0, 32'hFFFF_FFFE, "mdr_read_m2");
    step(MDRO | R2I, 5'd0, 32'h0, "r2_m2", 1'b1, 32'hFFFF_FFFE);
    step(RD | MDRI, 5'd0, 32'd3, "mdr_read3");
    step(MDRO | R4I, 5'd0, 32'h0, "r4_3", 1'b1, 32'd3);
    step(R2O | YI, 5'd0, 32'h0, "y_m2", 1'b1, 32'hFFFF_FFFE);
    step(R4O | ZHII | ZLOI, 5'd2, 32'h0, "smul_operand", 1'b1, 32'd3);
    step(ZLOO, 5'd0, 32'h0, "smul_zlo", 1'b1, 32'hFFFF_FFFA);
    step(ZHIO, 5'd0, 32'h0, "smul_zhi", 1'b1, 32'hFFFF_FFFF);

    step(R4O | ZHII | ZLOI, 5'd2, 32'h0, "mul_before_clear", 1'b1, 32'd3);
    step(CLR | LOI | HII, 5'd0, 32'h0, "clear_mid_seq", 1'b1, 32'h0);
    step(ZLOO | LOI, 5'd0, 32'h0, "zlo_after_clear", 1'b1, 32'h0);
    step(ZHIO, 5'd0, 32'h0, "zhi_after_clear", 1'b1, 32'h0);
    step(R2O, 5'd0, 32'h0, "r2_after_clear", 1'b1, 32'h0);

    step(RD | MDRI, 5'd0, 32'h1234_5678, "mdr_seed");
    step(MDRO | MDRI, 5'd0, 32'h0, "mdr_self_reload", 1'b1, 32'h1234_5678);
    step(MDRO, 5'd0, 32'h0, "mdr_kept", 1'b1, 32'h1234_5678);

    for (int i = 0; i < 400; i++) begin
      st = 22'($urandom);
      st[7:0] = st[7:0] & 8'($urandom);
`ifndef DATAPATH_HILO_OUT_EN
      st = st & ~(HIO | LOO);
`endif
      st = st & ~(INC | CLR);
      if ($urandom_range(0, 7) == 0)  st = st | INC;
      if ($urandom_range(0, 39) == 0) st = st | CLR;
      step(st, 5'($urandom_range(0, 15)), $urandom, "random_step");
    end

    @(posedge clk);
    #1;
    chk = 1'b0;
    s = '0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
